// File: rtl/alu_exec_pkg.sv
// Shared definitions for the execute-stage ALU: control codes, handshake FSM states,
// and the iteration counter width helper.
package alu_exec_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_MUL = 4'b0101;
  localparam logic [3:0] ALU_DIV = 4'b0100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int unsigned iter_cnt_w(input int unsigned width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative unsigned shift-add multiplier and (with ALU_DIV_EN) restoring divider.
// One bit per cycle for WIDTH cycles; lo/hi present the value produced by the current step.
module alu_iter_muldiv
  import alu_exec_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef ALU_DIV_EN
  input  logic             op_div,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  localparam int unsigned CNT_W = iter_cnt_w(WIDTH);

  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] step_lo, step_hi;
  logic [WIDTH:0]   mul_sum;
`ifdef ALU_DIV_EN
  logic             div_q, div_d;
  logic [WIDTH:0]   div_t;
  logic             div_ge;
`endif

  // Multiply: {hi,lo} shifts right with the partial sum; divide: {rem,quotient} shifts left.
  always_comb begin
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    step_hi = mul_sum[WIDTH:1];
    step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
`ifdef ALU_DIV_EN
    div_t  = {hi_q, lo_q[WIDTH-1]};
    div_ge = (div_t >= {1'b0, b_q});
    if (div_q) begin
      step_hi = div_ge ? (div_t[WIDTH-1:0] - b_q) : div_t[WIDTH-1:0];
      step_lo = {lo_q[WIDTH-2:0], div_ge};
    end
`endif
  end

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    lo_d   = lo_q;
    hi_d   = hi_q;
    b_d    = b_q;
`ifdef ALU_DIV_EN
    div_d  = div_q;
`endif
    if (start) begin
      busy_d = 1'b1;
      cnt_d  = CNT_W'(WIDTH);
      lo_d   = a;
      hi_d   = '0;
      b_d    = b;
`ifdef ALU_DIV_EN
      div_d  = op_div;
`endif
    end else if (busy_q) begin
      lo_d  = step_lo;
      hi_d  = step_hi;
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      lo_q   <= '0;
      hi_q   <= '0;
      b_q    <= '0;
`ifdef ALU_DIV_EN
      div_q  <= 1'b0;
`endif
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      lo_q   <= lo_d;
      hi_q   <= hi_d;
      b_q    <= b_d;
`ifdef ALU_DIV_EN
      div_q  <= div_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = busy_q && (cnt_q == CNT_W'(1));
  assign lo   = step_lo;
  assign hi   = step_hi;

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready handshake; single-cycle ops plus iterative MUL/DIV.
// Define ALU_DIV_EN to enable the unsigned divider on control code 0100.
module alu_exec_unit
  import alu_exec_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ctrl,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic             zero,
  output logic             illegal
);

  state_e           state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic             zero_q, zero_d;
  logic             illegal_q, illegal_d;

  logic             accept;
  logic             need_iter;
  logic [WIDTH-1:0] fast_res, fast_hi;
  logic             fast_ill;
  logic             eng_start, eng_busy, eng_done;
  logic [WIDTH-1:0] eng_lo, eng_hi;

  assign accept = in_valid && in_ready_q;

  always_comb begin
    fast_res  = '0;
    fast_hi   = '0;
    fast_ill  = 1'b0;
    need_iter = 1'b0;
    case (ctrl)
      ALU_AND: fast_res = op_a & op_b;
      ALU_OR:  fast_res = op_a | op_b;
      ALU_ADD: fast_res = op_a + op_b;
      ALU_SUB: fast_res = op_a - op_b;
      ALU_SLT: fast_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      ALU_MUL: need_iter = 1'b1;
`ifdef ALU_DIV_EN
      // Divide by zero resolves immediately without occupying the engine.
      ALU_DIV: begin
        if (op_b == '0) begin
          fast_res = '1;
          fast_hi  = op_a;
        end else begin
          need_iter = 1'b1;
        end
      end
`endif
      default: fast_ill = 1'b1;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = 1'b0;
    res_d       = res_q;
    hi_d        = hi_q;
    illegal_d   = illegal_q;
    eng_start   = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (accept) begin
          if (need_iter) begin
            eng_start  = 1'b1;
            in_ready_d = 1'b0;
            state_d    = BUSY;
          end else begin
            res_d       = fast_res;
            hi_d        = fast_hi;
            illegal_d   = fast_ill;
            out_valid_d = 1'b1;
            state_d     = DONE;
          end
        end
      end
      BUSY: begin
        if (eng_done) begin
          res_d       = eng_lo;
          hi_d        = eng_hi;
          illegal_d   = 1'b0;
          out_valid_d = 1'b1;
          in_ready_d  = 1'b1;
          state_d     = DONE;
        end else if (!eng_busy) begin
          in_ready_d = 1'b1;
          state_d    = IDLE;
        end
      end
      default: begin
        in_ready_d = 1'b1;
        state_d    = IDLE;
      end
    endcase
    zero_d = (res_d == '0);
    if (!out_valid_d) zero_d = zero_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      hi_q        <= '0;
      zero_q      <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      res_q       <= res_d;
      hi_q        <= hi_d;
      zero_q      <= zero_d;
      illegal_q   <= illegal_d;
    end
  end

  alu_iter_muldiv #(
    .WIDTH(WIDTH)
  ) u_iter (
    .clk   (clk),
    .rst   (rst),
    .start (eng_start),
`ifdef ALU_DIV_EN
    .op_div(ctrl == ALU_DIV),
`endif
    .a     (op_a),
    .b     (op_b),
    .busy  (eng_busy),
    .done  (eng_done),
    .lo    (eng_lo),
    .hi    (eng_hi)
  );

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = res_q;
  assign hi        = hi_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed cases plus random ops against an
// arithmetic reference model. Honours ALU_DIV_EN the same way as the design.
module tb_alu_exec_unit;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   ctrl = 4'b0000;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         out_valid;
  logic [W-1:0] result;
  logic [W-1:0] hi;
  logic         zero;
  logic         illegal;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_exec_unit #(
    .WIDTH(W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .ctrl     (ctrl),
    .op_a     (op_a),
    .op_b     (op_b),
    .out_valid(out_valid),
    .result   (result),
    .hi       (hi),
    .zero     (zero),
    .illegal  (illegal)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour; lat = extra edges after the accept edge before out_valid shows.
  task automatic model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output logic [31:0] h,
                       output logic ill, output int lat);
    logic [63:0] p;
    r = '0; h = '0; ill = 1'b0; lat = 0;
    case (c)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: r = a + b;
      4'b0110: r = a - b;
      4'b0111: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b0101: begin
        p = {32'd0, a} * {32'd0, b};
        r = p[31:0];
        h = p[63:32];
        lat = W;
      end
`ifdef ALU_DIV_EN
      4'b0100: begin
        if (b == 0) begin
          r = 32'hFFFF_FFFF;
          h = a;
        end else begin
          r = a / b;
          h = a % b;
          lat = W;
        end
      end
`endif
      default: ill = 1'b1;
    endcase
  endtask

  task automatic run_op(input string tag, input logic [3:0] c, input logic [31:0] a,
                        input logic [31:0] b);
    logic [31:0] er, eh;
    logic        ei, rdy_low;
    int          el, n;
    model(c, a, b, er, eh, ei, el);
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check({tag, "_ready_before"}, 64'(in_ready), 64'd1);
    ctrl = c; op_a = a; op_b = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    ctrl = 4'($urandom); op_a = $urandom; op_b = $urandom;
    n = 0;
    rdy_low = 1'b1;
    while (!out_valid && n < int'(W) + 5) begin
      if (in_ready) rdy_low = 1'b0;
      @(posedge clk); #1; n++;
    end
    check({tag, "_latency"}, 64'(n), 64'(el));
    check({tag, "_result"}, 64'(result), 64'(er));
    check({tag, "_hi"}, 64'(hi), 64'(eh));
    check({tag, "_zero"}, 64'(zero), 64'(er == 0));
    check({tag, "_illegal"}, 64'(illegal), 64'(ei));
    check({tag, "_ready_in_valid_cycle"}, 64'(in_ready), 64'd1);
    if (el != 0) check({tag, "_ready_low_busy"}, 64'(rdy_low), 64'd1);
    @(posedge clk); #1;
    check({tag, "_pulse"}, 64'(out_valid), 64'd0);
    check({tag, "_hold"}, 64'(result), 64'(er));
  endtask

  initial begin
    logic [3:0]  codes [9];
    logic [31:0] ra, rb, er, eh;
    logic        ei, seen;
    int          el;

    codes = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1111, 4'b0011};

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_zero", 64'(zero), 64'd0);
    check("rst_illegal", 64'(illegal), 64'd0);

    run_op("add_wrap", 4'b0010, 32'h7FFF_FFFF, 32'h1);
    run_op("add_ovf", 4'b0010, 32'hFFFF_FFFF, 32'h1);

    // Back-to-back single-cycle ops with in_valid held continuously.
    ctrl = 4'b0110; op_a = 32'd5; op_b = 32'd5; in_valid = 1'b1;
    @(posedge clk); #1;
    check("b2b_sub_valid", 64'(out_valid), 64'd1);
    check("b2b_sub_result", 64'(result), 64'd0);
    check("b2b_sub_zero", 64'(zero), 64'd1);
    check("b2b_sub_ready", 64'(in_ready), 64'd1);
    ctrl = 4'b0111; op_a = 32'hFFFF_FFFF; op_b = 32'd1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("b2b_slt_valid", 64'(out_valid), 64'd1);
    check("b2b_slt_result", 64'(result), 64'd1);
    check("b2b_slt_zero", 64'(zero), 64'd0);

    run_op("mul_max", 4'b0101, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("div_100_7", 4'b0100, 32'd100, 32'd7);
    run_op("div_by_0", 4'b0100, 32'd9, 32'd0);
    run_op("illegal_f", 4'b1111, 32'h1234, 32'h5678);
    run_op("and_mix", 4'b0000, 32'hF0F0_1234, 32'h0FF0_FFFF);

    // MUL with in_valid held and operands changing while busy: must be ignored.
    ctrl = 4'b0101; op_a = 32'd12345; op_b = 32'd6789; in_valid = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      op_a = $urandom; op_b = $urandom; ctrl = 4'b0010;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < int'(W) + 5; i++) begin
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    check("mul_latch_seen", 64'(seen), 64'd1);
    check("mul_latch_result", 64'(result), 64'(32'd12345 * 32'd6789));
    check("mul_latch_hi", 64'(hi), 64'd0);
    @(posedge clk); #1;
    check("mul_latch_no_extra", 64'(out_valid), 64'd0);

    // Reset in the middle of a multiply aborts it silently.
    ctrl = 4'b0101; op_a = 32'hDEAD_BEEF; op_b = 32'h1234_5678; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_ready", 64'(in_ready), 64'd1);
    check("abort_valid", 64'(out_valid), 64'd0);
    seen = 1'b0;
    for (int i = 0; i < int'(W) + 5; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("abort_no_valid", 64'(seen), 64'd0);
    run_op("abort_add", 4'b0010, 32'd40, 32'd2);

    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 3))
        0: rb = 32'($urandom_range(0, 15));
        1: ra = 32'($urandom_range(0, 1000));
        default: ;
      endcase
      run_op($sformatf("rand%0d", i), codes[$urandom_range(0, 8)], ra, rb);
    end

    model(4'b0100, 32'd1, 32'd1, er, eh, ei, el);
    run_op("div_code_last", 4'b0100, 32'd1, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
